// File: rtl/exec_queue_cdb.sv
// ---------------------------------------------------------------------------
// exec_queue_cdb
//   In-order issue queue for a single functional unit. It buffers dispatched
//   uops, snoops the common data bus (CDB) every cycle to wake operands that
//   are still waiting on a tag, and offers the head entry for issue once both
//   of its source operands hold valid data.
//
// Parameters
//   DEPTH   number of entries (power of 2, >= 2)
//   XLEN    operand data width
//   TAG_W   CDB / ROB tag width
//   CTRL_W  opaque control field width
//
// Entry layout, LSB first:
//   ctrl | rs2_tag | rs2_v | rs2_data | rs1_tag | rs1_v | rs1_data
//
// Ports
//   i_clk, i_rst_n           clock (rising edge), asynchronous active-low reset
//   i_flush                  synchronous squash of every entry
//   i_wr_en, i_wr_data       dispatch write; o_full / o_empty / o_count status
//   i_rd_en                  issue request; accepted only while o_head_ready
//   o_rd_data                head entry (combinational), 0 when empty
//   o_head_ready             queue not empty and both head operands valid
//   i_cdb_valid/tag/data     CDB broadcast snooped by all occupied entries
//
// Build option
//   CDB_WR_FWD_EN  when defined, an entry being written also captures a CDB
//                  broadcast of the same cycle for any operand waiting on
//                  that tag; otherwise the entry is stored exactly as given.
// ---------------------------------------------------------------------------
module exec_queue_cdb #(
  parameter  int DEPTH   = 4,
  parameter  int XLEN    = 32,
  parameter  int TAG_W   = 6,
  parameter  int CTRL_W  = 6,
  localparam int ENTRY_W = CTRL_W + 2 * (XLEN + 1 + TAG_W),
  localparam int AW      = $clog2(DEPTH),
  localparam int PW      = AW + 1
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_flush,
  input  logic               i_wr_en,
  input  logic [ENTRY_W-1:0] i_wr_data,
  output logic               o_full,
  output logic               o_empty,
  output logic [PW-1:0]      o_count,
  input  logic               i_rd_en,
  output logic [ENTRY_W-1:0] o_rd_data,
  output logic               o_head_ready,
  input  logic               i_cdb_valid,
  input  logic [TAG_W-1:0]   i_cdb_tag,
  input  logic [XLEN-1:0]    i_cdb_data
);

  localparam int RS2_TAG_LSB  = CTRL_W;
  localparam int RS2_V_BIT    = RS2_TAG_LSB + TAG_W;
  localparam int RS2_DATA_LSB = RS2_V_BIT + 1;
  localparam int RS1_TAG_LSB  = RS2_DATA_LSB + XLEN;
  localparam int RS1_V_BIT    = RS1_TAG_LSB + TAG_W;
  localparam int RS1_DATA_LSB = RS1_V_BIT + 1;

  logic [PW-1:0]      wp_reg;
  logic [PW-1:0]      rp_reg;
  logic [PW-1:0]      count_reg;
  logic [DEPTH-1:0]   valid_reg;
  logic [ENTRY_W-1:0] entry_reg [DEPTH];
  logic [ENTRY_W-1:0] snooped   [DEPTH];
  logic [ENTRY_W-1:0] head;
  logic [ENTRY_W-1:0] wr_entry;
  logic [AW-1:0]      wp_addr;
  logic [AW-1:0]      rp_addr;
  logic               wr_acc;
  logic               rd_acc;

  // Capture a matching CDB broadcast into any operand still waiting on it.
  // Operands that are already valid are left untouched.
  function automatic logic [ENTRY_W-1:0] snoop(input logic [ENTRY_W-1:0] e);
    logic [ENTRY_W-1:0] r;
    r = e;
    if (i_cdb_valid && !e[RS1_V_BIT] && (e[RS1_TAG_LSB +: TAG_W] == i_cdb_tag)) begin
      r[RS1_DATA_LSB +: XLEN] = i_cdb_data;
      r[RS1_V_BIT]            = 1'b1;
    end
    if (i_cdb_valid && !e[RS2_V_BIT] && (e[RS2_TAG_LSB +: TAG_W] == i_cdb_tag)) begin
      r[RS2_DATA_LSB +: XLEN] = i_cdb_data;
      r[RS2_V_BIT]            = 1'b1;
    end
    return r;
  endfunction

  assign wp_addr = wp_reg[AW-1:0];
  assign rp_addr = rp_reg[AW-1:0];

  assign o_empty      = (wp_reg == rp_reg);
  assign o_full       = (wp_addr == rp_addr) && (wp_reg[AW] != rp_reg[AW]);
  assign o_count      = count_reg;
  assign head         = entry_reg[rp_addr];
  assign o_head_ready = !o_empty && head[RS1_V_BIT] && head[RS2_V_BIT];
  assign o_rd_data    = o_empty ? '0 : head;

  // Flush wins over everything else that cycle.
  assign wr_acc = i_wr_en && !o_full && !i_flush;
  assign rd_acc = i_rd_en && o_head_ready && !i_flush;

`ifdef CDB_WR_FWD_EN
  assign wr_entry = snoop(i_wr_data);
`else
  assign wr_entry = i_wr_data;
`endif

  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_snoop
      assign snooped[gi] = snoop(entry_reg[gi]);
    end
  endgenerate

  // Pointers, occupancy and per-entry valid bits.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wp_reg    <= '0;
      rp_reg    <= '0;
      count_reg <= '0;
      valid_reg <= '0;
    end else if (i_flush) begin
      wp_reg    <= '0;
      rp_reg    <= '0;
      count_reg <= '0;
      valid_reg <= '0;
    end else begin
      if (wr_acc) begin
        wp_reg             <= wp_reg + 1'b1;
        valid_reg[wp_addr] <= 1'b1;
      end
      // A write never targets the head slot while a read is possible, so
      // these two valid-bit updates cannot collide.
      if (rd_acc) begin
        rp_reg             <= rp_reg + 1'b1;
        valid_reg[rp_addr] <= 1'b0;
      end
      case ({wr_acc, rd_acc})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

  // Entry payload: no reset needed, occupancy is tracked by valid_reg and
  // the pointers. Free slots do not snoop.
  always_ff @(posedge i_clk) begin
    if (!i_flush) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (wr_acc && (wp_addr == AW'(i))) begin
          entry_reg[i] <= wr_entry;
        end else if (valid_reg[i]) begin
          entry_reg[i] <= snooped[i];
        end
      end
    end
  end

endmodule
